// File: rtl/neuron_pkg.sv
// Shared activation types and the requantization helper
// used by neuron post-processing and later layers.
package neuron_pkg;

    localparam int ACT_W     = 8;
    localparam int ACT_MAX   = 255;
    localparam int ACC_MAX_W = 64;

    typedef logic [ACT_W-1:0] act_t;

    // ReLU, arithmetic right shift, then clamp to ACT_MAX.
    // Callers sign-extend their accumulator to ACC_MAX_W.
    function automatic act_t requant(
        input logic signed [ACC_MAX_W-1:0] acc,
        input int unsigned                 shift
    );
        logic signed [ACC_MAX_W-1:0] q;
        logic signed [ACC_MAX_W-1:0] lim;
        act_t                        res;
        lim = ACC_MAX_W'(ACT_MAX);
        q   = acc >>> shift;
        if (acc < 0) begin
            res = '0;
        end else if (q > lim) begin
            res = ACT_W'(ACT_MAX);
        end else begin
            res = q[ACT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a pop frees its slot for a push
// at the same edge, so full + pop + push is accepted.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = empty ? '0 : mem_q[rptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_en) wptr_d = wptr_q + AW'(1);
        if (rd_en) rptr_d = rptr_q + AW'(1);
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/neuron_post.sv
// ReLU/requant/saturate stage feeding an output FIFO.
// Define NEURON_POST_ARGMAX_EN for the per-frame argmax tracker.
module neuron_post
    import neuron_pkg::*;
#(
    parameter int          N         = 9,
    parameter int unsigned SHIFT     = 7,
    parameter int          DEPTH     = 4,
    parameter int          FRAME_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [N+7:0]          neuron_out,
    input  logic                         in_valid,
    output act_t                         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overflow
`ifdef NEURON_POST_ARGMAX_EN
    ,
    output logic [$clog2(FRAME_LEN)-1:0] class_idx,
    output logic                         class_valid
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic signed [ACC_MAX_W-1:0] acc_ext;
    logic                        s1_valid_q, s1_valid_d;
    act_t                        s1_data_q, s1_data_d;
    logic                        overflow_q, overflow_d;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [CW-1:0]               fifo_count;
    logic                        pop;
    logic                        accept;
    logic                        drop;

    assign acc_ext   = ACC_MAX_W'(neuron_out);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign accept    = pop || !fifo_full;
    assign drop      = s1_valid_q && !pop && (fifo_count == CW'(DEPTH));
    assign overflow  = overflow_q;

    // Stage 1 quantizes every strobe; it never stalls.
    always_comb begin
        s1_valid_d = in_valid;
        s1_data_d  = s1_data_q;
        overflow_d = overflow_q | drop;
        if (in_valid) s1_data_d = requant(acc_ext, SHIFT);
    end

    // Stage 1 and sticky drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (ACT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (s1_valid_q && accept),
        .pop   (pop),
        .wdata (s1_data_q),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef NEURON_POST_ARGMAX_EN
    localparam int IW = $clog2(FRAME_LEN);

    logic [IW-1:0] frame_q, frame_d;
    act_t          max_q, max_d;
    logic [IW-1:0] max_idx_q, max_idx_d;
    logic [IW-1:0] class_idx_q, class_idx_d;
    logic          class_valid_q, class_valid_d;
    logic          hit;

    assign hit         = s1_data_q > max_q;
    assign class_idx   = class_idx_q;
    assign class_valid = class_valid_q;

    // Track strict max over the frame; ties keep the first index.
    always_comb begin
        frame_d       = frame_q;
        max_d         = max_q;
        max_idx_d     = max_idx_q;
        class_idx_d   = class_idx_q;
        class_valid_d = 1'b0;
        if (s1_valid_q) begin
            if (hit) begin
                max_d     = s1_data_q;
                max_idx_d = frame_q;
            end
            if (frame_q == IW'(FRAME_LEN - 1)) begin
                class_valid_d = 1'b1;
                class_idx_d   = hit ? frame_q : max_idx_q;
                frame_d       = '0;
                max_d         = '0;
                max_idx_d     = '0;
            end else begin
                frame_d = frame_q + IW'(1);
            end
        end
    end

    // Argmax tracker registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q       <= '0;
            max_q         <= '0;
            max_idx_q     <= '0;
            class_idx_q   <= '0;
            class_valid_q <= 1'b0;
        end else begin
            frame_q       <= frame_d;
            max_q         <= max_d;
            max_idx_q     <= max_idx_d;
            class_idx_q   <= class_idx_d;
            class_valid_q <= class_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_neuron_post.sv
// Directed bench for neuron_post with a queue-level
// reference model checked on every falling edge.
module tb_neuron_post;

    localparam int N         = 9;
    localparam int SHIFT     = 7;
    localparam int DEPTH     = 4;
    localparam int FRAME_LEN = 4;
    localparam int IN_W      = N + 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   out_ready = 1'b0;
    logic signed [IN_W-1:0] neuron_out = '0;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   overflow;
`ifdef NEURON_POST_ARGMAX_EN
    logic [1:0]             class_idx;
    logic                   class_valid;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    neuron_post #(
        .N         (N),
        .SHIFT     (SHIFT),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .neuron_out  (neuron_out),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow)
`ifdef NEURON_POST_ARGMAX_EN
        ,
        .class_idx   (class_idx),
        .class_valid (class_valid)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference: ReLU, divide by 2^SHIFT, clamp to 255.
    function automatic int q_model(input int v);
        int q;
        if (v < 0) return 0;
        q = v / (1 << SHIFT);
        return (q > 255) ? 255 : q;
    endfunction

    int mq[$];
    int m_frame[$];
    bit m_s1_v;
    int m_s1_val;
    bit m_ovf;
    bit m_cv;
    int m_ci;

    always @(posedge clk or negedge rst) begin : model
        int v;
        int best;
        int bi;
        if (!rst) begin
            mq.delete();
            m_frame.delete();
            m_s1_v   = 1'b0;
            m_s1_val = 0;
            m_ovf    = 1'b0;
            m_cv     = 1'b0;
            m_ci     = 0;
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            m_cv = 1'b0;
            if (m_s1_v) begin
                if (mq.size() < DEPTH) mq.push_back(m_s1_val);
                else m_ovf = 1'b1;
                m_frame.push_back(m_s1_val);
                if (m_frame.size() == FRAME_LEN) begin
                    best = 0;
                    bi   = 0;
                    foreach (m_frame[i])
                        if (m_frame[i] > best) begin
                            best = m_frame[i];
                            bi   = i;
                        end
                    m_ci = bi;
                    m_cv = 1'b1;
                    m_frame.delete();
                end
            end
            v        = neuron_out;
            m_s1_v   = in_valid;
            m_s1_val = q_model(v);
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0)
            chk("out_data", 32'(out_data), mq[0]);
        else if (!rst)
            chk("out_data_rst", 32'(out_data), 0);
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef NEURON_POST_ARGMAX_EN
        chk("class_valid", 32'(class_valid), 32'(m_cv));
        chk("class_idx", 32'(class_idx), m_ci);
`endif
    end

    int got[$];
    int cls[$];

    always @(posedge clk)
        if (rst && out_valid && out_ready) got.push_back(int'(out_data));

`ifdef NEURON_POST_ARGMAX_EN
    always @(negedge clk)
        if (class_valid) cls.push_back(int'(class_idx));
`endif

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int v);
        neuron_out = IN_W'(v);
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    int fvals[8] = '{3, 9, 9, 2, 0, 0, 0, 0};
    int gvals[4] = '{1, 7, 2, 3};

    initial begin
        // Reset held with strobes present.
        rst        = 1'b0;
        in_valid   = 1'b1;
        neuron_out = IN_W'(1024);
        tick(3);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        in_valid = 1'b0;
        rst      = 1'b1;

        // Latency and quantization.
        pulse(1024);
        chk("lat_t1", 32'(out_valid), 0);
        tick();
        chk("lat_t2", 32'(out_valid), 1);
        chk("q_1024", 32'(out_data), 8);
        pop_one();
        pulse(-500);
        tick();
        chk("neg_valid", 32'(out_valid), 1);
        chk("q_neg", 32'(out_data), 0);
        pop_one();
        pulse(65535);
        tick();
        chk("q_sat", 32'(out_data), 255);
        pop_one();
        chk("empty_after", 32'(out_valid), 0);

        // Fill past capacity with no consumer.
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            neuron_out = IN_W'(128 * k);
            tick();
        end
        in_valid = 1'b0;
        tick(2);
        chk("ovf_set", 32'(overflow), 1);
        for (int k = 1; k <= 4; k++) begin
            chk("drain", 32'(out_data), k);
            pop_one();
        end
        chk("drained", 32'(out_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Full FIFO with pop and push on the same edges.
        reset_pulse();
        chk("ovf_cleared", 32'(overflow), 0);
        got.delete();
        in_valid = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            neuron_out = IN_W'(128 * k);
            tick();
            if (k == 5) out_ready = 1'b1;
        end
        in_valid = 1'b0;
        tick(8);
        out_ready = 1'b0;
        chk("wrap_no_ovf", 32'(overflow), 0);
        chk("wrap_count", got.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < got.size()) chk("wrap_order", got[i], i + 1);

`ifdef NEURON_POST_ARGMAX_EN
        // Two argmax frames.
        reset_pulse();
        cls.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            neuron_out = IN_W'(128 * fvals[i]);
            tick();
        end
        in_valid = 1'b0;
        tick(4);
        out_ready = 1'b0;
        chk("frames", cls.size(), 2);
        if (cls.size() > 0) chk("argmax_tie", cls[0], 1);
        if (cls.size() > 1) chk("argmax_zero", cls[1], 0);
`endif

        // Reset with two stored and one in stage 1.
        reset_pulse();
        in_valid = 1'b1;
        for (int k = 10; k <= 12; k++) begin
            neuron_out = IN_W'(128 * k);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        tick(2);
        rst = 1'b1;
        tick(4);
        chk("no_inflight", 32'(out_valid), 0);

`ifdef NEURON_POST_ARGMAX_EN
        cls.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            neuron_out = IN_W'(128 * gvals[i]);
            tick();
        end
        in_valid = 1'b0;
        tick(4);
        out_ready = 1'b0;
        chk("frame_restart", cls.size(), 1);
        if (cls.size() > 0) chk("argmax_after_rst", cls[0], 1);
`endif

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
